// File: rtl/or_event_reader_if.sv
// Read handshake bundle between a requester (master) and the event reader (slave).
// The requester raises rd_req; the reader answers with rd_ack plus a snapshot.
interface or_event_reader_if #(
    parameter int WIDTH = 8
);
    logic             rd_req;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ovf;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data,
        input  rd_ovf
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data,
        output rd_ovf
    );
endinterface

// File: rtl/or_event_reader.sv
// Sticky OR event collector: latches enabled events into pending bits, raises irq,
// and hands the pending word to a requester through a four-phase req/ack read.
module or_event_reader #(
    parameter int WIDTH = 8,
    parameter int EDGE  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_evt_in,
    input  logic [WIDTH-1:0]  i_mask,
    output logic [WIDTH-1:0]  o_pending,
    output logic              o_irq,
    or_event_reader_if.slave  bus
);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_evt_prev;
    logic             r_ovf;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_ovf;

    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             w_ovf_hit;
    logic             w_ovf_nxt;

    assign w_det = (EDGE != 0) ? (i_evt_in & ~r_evt_prev) : i_evt_in;
    assign w_acc = w_det & i_mask;

    // Clear only the bits captured by the snapshot, so a same-cycle event survives the read.
    assign w_clr         = w_accept ? r_pending : '0;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_acc;
    assign w_ovf_hit     = |(w_acc & r_pending & ~w_clr);
    assign w_ovf_nxt     = (w_accept ? 1'b0 : r_ovf) | w_ovf_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rd_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.rd_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_evt_prev <= '0;
            r_ovf      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_evt_prev <= i_evt_in;
            r_ovf      <= w_ovf_nxt;
            if (w_accept) begin
                r_rd_data <= r_pending;
                r_rd_ovf  <= r_ovf;
            end
        end
    end

    assign o_pending   = r_pending;
    assign o_irq       = |r_pending;
    assign bus.rd_ack  = (r_state == S_ACK);
    assign bus.rd_data = r_rd_data;
    assign bus.rd_ovf  = r_rd_ovf;

endmodule

// File: tb/tb_or_event_reader.sv
// Checks an edge-mode and a level-mode or_event_reader against a per-bit reference model.
module tb_or_event_reader;

    logic       clk;
    logic       rst_n;
    logic [7:0] evt;
    logic [7:0] mask;
    logic       req;

    logic [7:0] pend_e, pend_l;
    logic       irq_e, irq_l;

    int n_checks;
    int n_errors;

    // Reference state, index 0 = edge instance, 1 = level instance
    logic [7:0] m_pend [2];
    logic [7:0] m_prev [2];
    logic       m_ovf  [2];
    logic       m_ack  [2];
    logic [7:0] m_data [2];
    logic       m_rovf [2];

    logic [7:0] saved;

    or_event_reader_if #(.WIDTH(8)) ifc_e ();
    or_event_reader_if #(.WIDTH(8)) ifc_l ();

    assign ifc_e.rd_req = req;
    assign ifc_l.rd_req = req;

    or_event_reader #(.WIDTH(8), .EDGE(1)) u_edge (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_evt_in  (evt),
        .i_mask    (mask),
        .o_pending (pend_e),
        .o_irq     (irq_e),
        .bus       (ifc_e)
    );

    or_event_reader #(.WIDTH(8), .EDGE(0)) u_lvl (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_evt_in  (evt),
        .i_mask    (mask),
        .o_pending (pend_l),
        .o_irq     (irq_l),
        .bus       (ifc_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0;
            m_prev[k] = '0;
            m_ovf[k]  = 1'b0;
            m_ack[k]  = 1'b0;
            m_data[k] = '0;
            m_rovf[k] = 1'b0;
        end
    endtask

    // One clock of the reader described bit by bit: a read snapshots everything,
    // then each bit is either freshly hit, cleared by the read, or left alone.
    task automatic model_step(input int k, input bit edge_mode);
        logic [7:0] acc;
        bit         accept;
        acc    = (edge_mode ? (evt & ~m_prev[k]) : evt) & mask;
        accept = !m_ack[k] && req;
        if (accept) begin
            m_data[k] = m_pend[k];
            m_rovf[k] = m_ovf[k];
            m_ovf[k]  = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (acc[i]) begin
                if (m_pend[k][i] && !accept) m_ovf[k] = 1'b1;
                m_pend[k][i] = 1'b1;
            end else if (accept) begin
                m_pend[k][i] = 1'b0;
            end
        end
        if (accept)      m_ack[k] = 1'b1;
        else if (!req)   m_ack[k] = 1'b0;
        m_prev[k] = evt;
    endtask

    task automatic compare_all();
        chk("edge_pending", pend_e, m_pend[0]);
        chk("edge_irq", 8'(irq_e), 8'(|m_pend[0]));
        chk("edge_ack", 8'(ifc_e.rd_ack), 8'(m_ack[0]));
        chk("edge_data", ifc_e.rd_data, m_data[0]);
        chk("edge_rovf", 8'(ifc_e.rd_ovf), 8'(m_rovf[0]));
        chk("lvl_pending", pend_l, m_pend[1]);
        chk("lvl_irq", 8'(irq_l), 8'(|m_pend[1]));
        chk("lvl_ack", 8'(ifc_l.rd_ack), 8'(m_ack[1]));
        chk("lvl_data", ifc_l.rd_data, m_data[1]);
        chk("lvl_rovf", 8'(ifc_l.rd_ovf), 8'(m_rovf[1]));
    endtask

    // Inputs are set after a falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        evt   = 8'h00;
        mask  = 8'hFF;
        req   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single rising edge on bit 2, then held high
        evt = 8'h04; cycle();
        chk("t1_pend", pend_e, 8'h04);
        chk("t1_irq", 8'(irq_e), 8'h01);
        cycle(); cycle();
        chk("t1_hold", pend_e, 8'h04);
        evt = 8'h00; cycle();

        // Second pulse on a pending bit -> overflow reported by the read
        evt = 8'h04; cycle();
        evt = 8'h00; cycle();
        req = 1'b1; cycle();
        chk("t2_data", ifc_e.rd_data, 8'h04);
        chk("t2_ovf", 8'(ifc_e.rd_ovf), 8'h01);
        chk("t2_clear", pend_e, 8'h00);
        req = 1'b0; cycle(); cycle();
        req = 1'b1; cycle();
        chk("t2_ovf_cleared", 8'(ifc_e.rd_ovf), 8'h00);
        req = 1'b0; cycle();

        // Event arriving on the very edge that accepts the read
        evt = 8'h01; cycle();
        evt = 8'h00; cycle();
        evt = 8'h01; req = 1'b1; cycle();
        chk("t3_data", ifc_e.rd_data, 8'h01);
        chk("t3_ack", 8'(ifc_e.rd_ack), 8'h01);
        chk("t3_retained", pend_e, 8'h01);
        chk("t3_ovf", 8'(ifc_e.rd_ovf), 8'h00);
        evt = 8'h00; req = 1'b0; cycle();
        req = 1'b1; cycle();
        req = 1'b0; cycle();

        // Masking: only enabled bits latch; mask drop keeps pending
        mask = 8'hF0;
        evt = 8'h0F; cycle();
        evt = 8'hF0; cycle();
        evt = 8'h00; cycle();
        chk("t4_masked", pend_e, 8'hF0);
        mask = 8'h00; cycle(); cycle();
        chk("t4_sticky", pend_e, 8'hF0);
        req = 1'b1; cycle();
        chk("t4_data", ifc_e.rd_data, 8'hF0);
        req = 1'b0; cycle();
        mask = 8'hFF; cycle();

        // Long request with events accumulating during ACK
        req = 1'b1; cycle();
        saved = ifc_e.rd_data;
        evt = 8'h80; cycle();
        evt = 8'h00; cycle();
        evt = 8'h80; cycle();
        evt = 8'h00; cycle();
        chk("t5_ack_held", 8'(ifc_e.rd_ack), 8'h01);
        chk("t5_data_held", ifc_e.rd_data, saved);
        chk("t5_accum", pend_e, 8'h80);
        req = 1'b0; cycle();
        chk("t5_ack_drop", 8'(ifc_e.rd_ack), 8'h00);
        cycle();
        req = 1'b1; cycle();
        chk("t5_second", ifc_e.rd_data, 8'h80);
        req = 1'b0; cycle();

        // Asynchronous reset in the middle of a handshake
        evt = 8'h02; cycle();
        req = 1'b1; cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ack", 8'(ifc_e.rd_ack), 8'h00);
        chk("t6_rst_pend", pend_e, 8'h00);
        chk("t6_rst_irq", 8'(irq_e), 8'h00);
        chk("t6_rst_data", ifc_e.rd_data, 8'h00);
        compare_all();
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Level mode with a held input re-sets after every read
        for (int r = 0; r < 3; r++) begin
            cycle();
            req = 1'b1; cycle();
            chk("t6_lvl_reset", 8'(pend_l[1]), 8'h01);
            req = 1'b0; cycle();
        end
        evt = 8'h00; cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            evt = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = ~req;
            cycle();
        end
        req = 1'b0; cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
